// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared constants for the AES-128 result capture stage.
//   - FSM state encoding (IDLE / WAIT / SEND) as 2-bit localparams
//   - Ciphertext block width and output word width
//   - Default pipeline latency of the AES core
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] SEND = 2'd2;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_WORD_W  = 32;

    localparam int AES_LATENCY_DEFAULT = 21;

endpackage

// File: rtl/aes_word_mux.sv
// ---------------------------------------------------------------------------
// aes_word_mux
// Purely combinational 128 -> 32 word selector. Index 0 selects the most
// significant word, so words leave MSB first.
// Ports:
//   block  in   128  captured ciphertext
//   idx    in   2    word index (0 = bits [127:96], 3 = bits [31:0])
//   word   out  32   selected word
// ---------------------------------------------------------------------------
module aes_word_mux
    import aes_pkg::*;
(
    input  logic [AES_BLOCK_W-1:0] block,
    input  logic [1:0]             idx,
    output logic [AES_WORD_W-1:0]  word
);

    always_comb begin
        word = '0;
        case (idx)
            2'd0:    word = block[AES_BLOCK_W-1                -: AES_WORD_W];
            2'd1:    word = block[AES_BLOCK_W-1 - AES_WORD_W   -: AES_WORD_W];
            2'd2:    word = block[AES_BLOCK_W-1 - 2*AES_WORD_W -: AES_WORD_W];
            default: word = block[AES_BLOCK_W-1 - 3*AES_WORD_W -: AES_WORD_W];
        endcase
    end

endmodule

// File: rtl/aes_result_capture.sv
// ---------------------------------------------------------------------------
// aes_result_capture
// Downstream stage of the pipelined AES-128 core. After an issue pulse it
// waits AES_LATENCY edges, captures the 128-bit ciphertext and hands it out
// as four 32-bit words (MSB first) over a valid/ready handshake. Starts that
// arrive while a block is still in flight are dropped and flagged.
//
// Parameters:
//   AES_LATENCY  edges from the start edge to the capture edge (1..63)
//   CNT_W        latency counter width, 2**CNT_W > AES_LATENCY
//
// Ports:
//   clk              in   1    system clock, rising edge
//   reset_in         in   1    synchronous active-high reset
//   start_in         in   1    issue pulse
//   aes_out_in       in   128  ciphertext bus from the core
//   word_ready_in    in   1    consumer ready
//   word_valid_out   out  1    word_data_out valid
//   word_data_out    out  32   current ciphertext word
//   word_idx_out     out  2    current word index (0 = bits [127:96])
//   busy_out         out  1    high while waiting or sending
//   done_out         out  1    one-cycle pulse after the last word is taken
//   overrun_out      out  1    sticky, a start was dropped
//   clr_overrun_in   in   1    clears overrun_out (and overrun_cnt_out)
//   overrun_cnt_out  out  8    saturating dropped-start count
//                              (only with AES_CAPTURE_OVERRUN_CNT_EN)
//
// Build option: define AES_CAPTURE_OVERRUN_CNT_EN to add overrun_cnt_out.
// ---------------------------------------------------------------------------
module aes_result_capture
    import aes_pkg::*;
#(
    parameter int AES_LATENCY = AES_LATENCY_DEFAULT,
    parameter int CNT_W       = 6
)(
    input  logic                   clk,
    input  logic                   reset_in,
    input  logic                   start_in,
    input  logic [AES_BLOCK_W-1:0] aes_out_in,
    input  logic                   word_ready_in,
    output logic                   word_valid_out,
    output logic [AES_WORD_W-1:0]  word_data_out,
    output logic [1:0]             word_idx_out,
    output logic                   busy_out,
    output logic                   done_out,
    output logic                   overrun_out,
    input  logic                   clr_overrun_in
`ifdef AES_CAPTURE_OVERRUN_CNT_EN
    ,
    output logic [7:0]             overrun_cnt_out
`endif
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(AES_LATENCY - 1);

    logic [1:0]             state;
    logic [1:0]             state_next;
    logic [CNT_W-1:0]       lat_cnt;
    logic [AES_BLOCK_W-1:0] result;
    logic [1:0]             idx;
    logic                   busy_q;
    logic                   done_q;
    logic                   overrun_q;

    logic handshake;
    logic last_hs;
    logic capture;
    logic accept;
    logic drop;

    // A start is taken from IDLE or exactly on the final handshake; any
    // other start while a block is in flight is dropped.
    assign handshake = (state == SEND) && word_ready_in;
    assign last_hs   = handshake && (idx == 2'd3);
    assign capture   = (state == WAIT) && (lat_cnt == '0);
    assign accept    = start_in && ((state == IDLE) || last_hs);
    assign drop      = start_in && ((state == WAIT) || ((state == SEND) && !last_hs));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_in) state_next = WAIT;
            WAIT:    if (lat_cnt == '0) state_next = SEND;
            SEND:    if (last_hs) state_next = start_in ? WAIT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Main sequencing: state, latency counter, captured block and word index.
    // busy/done are registered so no input reaches an output combinationally.
    always_ff @(posedge clk) begin
        if (reset_in) begin
            state   <= IDLE;
            lat_cnt <= '0;
            result  <= '0;
            idx     <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state  <= state_next;
            busy_q <= (state_next != IDLE);
            done_q <= last_hs;

            if (accept) begin
                lat_cnt <= LAT_LOAD;
            end else if ((state == WAIT) && (lat_cnt != '0)) begin
                lat_cnt <= lat_cnt - 1'b1;
            end

            if (capture) begin
                result <= aes_out_in;
            end

            if (capture || last_hs) begin
                idx <= 2'd0;
            end else if (handshake) begin
                idx <= idx + 1'b1;
            end
        end
    end

    // Sticky overrun flag; a drop in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (reset_in) begin
            overrun_q <= 1'b0;
        end else if (drop) begin
            overrun_q <= 1'b1;
        end else if (clr_overrun_in) begin
            overrun_q <= 1'b0;
        end
    end

`ifdef AES_CAPTURE_OVERRUN_CNT_EN
    logic [7:0] overrun_cnt;

    // Saturating drop counter; a clear with a simultaneous drop leaves 1.
    always_ff @(posedge clk) begin
        if (reset_in) begin
            overrun_cnt <= 8'd0;
        end else if (clr_overrun_in) begin
            overrun_cnt <= drop ? 8'd1 : 8'd0;
        end else if (drop && (overrun_cnt != 8'hFF)) begin
            overrun_cnt <= overrun_cnt + 8'd1;
        end
    end

    assign overrun_cnt_out = overrun_cnt;
`endif

    aes_word_mux u_word_mux (
        .block (result),
        .idx   (idx),
        .word  (word_data_out)
    );

    assign word_valid_out = (state == SEND);
    assign word_idx_out   = idx;
    assign busy_out       = busy_q;
    assign done_out       = done_q;
    assign overrun_out    = overrun_q;

endmodule
